// File: rtl/mmio_pkg.sv
// Shared MMIO definitions: bus command encodings, register map and address decode.
package mmio_pkg;

    localparam logic [1:0] MREAD  = 2'b11;
    localparam logic [1:0] MWRITE = 2'b01;

    localparam logic [8:0] ADDR_LED    = 9'h100;
    localparam logic [8:0] ADDR_SW     = 9'h140;
    localparam logic [8:0] ADDR_CYCLE  = 9'h180;
    localparam logic [8:0] ADDR_TX     = 9'h1C0;
    localparam logic [8:0] ADDR_STATUS = 9'h1C1;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_LED,
        REG_SW,
        REG_CYCLE,
        REG_TX,
        REG_STATUS
    } reg_sel_t;

    // Unselected addresses (bit 8 clear) never match a map entry.
    function automatic reg_sel_t decode_addr(input logic [8:0] addr);
        reg_sel_t sel;
        sel = REG_NONE;
        case (addr)
            ADDR_LED:    sel = REG_LED;
            ADDR_SW:     sel = REG_SW;
            ADDR_CYCLE:  sel = REG_CYCLE;
            ADDR_TX:     sel = REG_TX;
            ADDR_STATUS: sel = REG_STATUS;
            default:     sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mmio_responder_if.sv
// CPU-side MMIO command/address/write-data bus plus the TX stream handshake.
interface mmio_responder_if #(
    parameter int data_width = 16
);
    logic [1:0]            mem_cmd;
    logic [8:0]            mem_addr;
    logic [data_width-1:0] din;
    logic [data_width-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (
        output mem_cmd, mem_addr, din, tx_ready,
        input  tx_data, tx_valid
    );

    modport slave (
        input  mem_cmd, mem_addr, din, tx_ready,
        output tx_data, tx_valid
    );
endinterface

// File: rtl/mmio_responder_tx_fifo.sv
// TX FIFO: circular buffer with read/write pointers and an occupancy count.
module tx_fifo #(
    parameter int data_width = 16,
    parameter int fifo_depth = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [data_width-1:0]         push_data,
    input  logic                          pop,
    output logic [data_width-1:0]         head,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(fifo_depth):0]   count,
    output logic                          drop
);
    localparam int ptr_width = $clog2(fifo_depth);
    localparam logic [ptr_width:0] depth_count = (ptr_width + 1)'(fifo_depth);

    logic [data_width-1:0] mem [fifo_depth];
    logic [ptr_width-1:0]  rd_ptr;
    logic [ptr_width-1:0]  wr_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == depth_count);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !reset;
    // A pop at the same edge frees the slot, so a full FIFO still accepts the push.
    assign do_push = push && (!full || do_pop) && !reset;
    assign drop    = push && !reset && !do_push;
    assign head    = mem[rd_ptr];

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at fifo_depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder: LED, switch, cycle-counter, TX-FIFO and status registers.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int data_width = 16,
    parameter int fifo_depth = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    mmio_responder_if.slave       bus,
    input  logic [7:0]            sw,
    output logic [7:0]            led,
    output logic [data_width-1:0] mdata
);
    reg_sel_t                   sel;
    logic                       is_read;
    logic                       is_write;
    logic                       access_start;
    logic [10:0]                prev_access;
    logic                       prev_valid;
    logic [7:0]                 sw_meta;
    logic [7:0]                 sw_sync;
    logic [data_width-1:0]      cycle_count;
    logic                       overflow;
    logic                       push;
    logic                       pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       fifo_drop;
    logic [$clog2(fifo_depth):0] fifo_count;
    logic [data_width-1:0]      rd_value;

    assign sel          = decode_addr(bus.mem_addr);
    assign is_read      = (bus.mem_cmd == MREAD)  && bus.mem_addr[8];
    assign is_write     = (bus.mem_cmd == MWRITE) && bus.mem_addr[8];
    // A write held over several cycles acts once: only the first cycle of a new {cmd, addr}.
    assign access_start = is_write && !(prev_valid && (prev_access == {bus.mem_cmd, bus.mem_addr}));
    assign push         = access_start && (sel == REG_TX);
    assign pop          = bus.tx_valid && bus.tx_ready;
    assign bus.tx_valid = (fifo_count != '0);

    // Record last cycle's command/address; reset forgets it so a held command restarts.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_valid  <= 1'b0;
            prev_access <= '0;
        end else begin
            prev_valid  <= 1'b1;
            prev_access <= {bus.mem_cmd, bus.mem_addr};
        end
    end

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    // LED register, loaded once per write access.
    always_ff @(posedge clk) begin
        if (reset) begin
            led <= '0;
        end else if (access_start && (sel == REG_LED)) begin
            led <= bus.din[7:0];
        end
    end

    // Free-running cycle counter; a clear write wins over the increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (access_start && (sel == REG_CYCLE)) begin
            cycle_count <= '0;
        end else begin
            cycle_count <= cycle_count + 1'b1;
        end
    end

    // Sticky overflow flag; a dropped push wins over a status clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (fifo_drop) begin
            overflow <= 1'b1;
        end else if (access_start && (sel == REG_STATUS)) begin
            overflow <= 1'b0;
        end
    end

    // Read data mux; unmapped and write-only registers read as zero.
    always_comb begin
        rd_value = '0;
        case (sel)
            REG_LED:    rd_value = data_width'(led);
            REG_SW:     rd_value = data_width'(sw_sync);
            REG_CYCLE:  rd_value = cycle_count;
            REG_STATUS: rd_value = data_width'({overflow, fifo_full, fifo_empty});
            default:    rd_value = '0;
        endcase
    end

    assign mdata = is_read ? rd_value : 'z;

    tx_fifo #(
        .data_width(data_width),
        .fifo_depth(fifo_depth)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (bus.din),
        .pop       (pop),
        .head      (bus.tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .drop      (fifo_drop)
    );

endmodule

// File: doc/mmio_responder.md
MMIO_RESPONDER -- requirements
Module: mmio_responder

Interface
REQ-001 SHALL have parameter data_width, 16, width of bus data and registers.
REQ-002 SHALL have parameter fifo_depth, 4, TX FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_cmd  input  2  bus command: 2'b11 MREAD, 2'b01 MWRITE, others idle.
REQ-006 SHALL have port mem_addr  input  9  bus address; block is selected only when mem_addr[8]=1.
REQ-007 SHALL have port din  input  data_width  write data from CPU.
REQ-008 SHALL have port mdata  output  data_width  read data; driven only during a selected MREAD, else all 'z'.
REQ-009 SHALL have port sw  input  8  asynchronous switch inputs.
REQ-010 SHALL have port led  output  8  LED register contents.
REQ-011 SHALL have port tx_data  output  data_width  FIFO head word.
REQ-012 SHALL have port tx_valid  output  1  FIFO non-empty.
REQ-013 SHALL have port tx_ready  input  1  consumer accepts head when tx_valid & tx_ready at rising edge.

Function
REQ-014 SHALL decode address map: 0x100 LED (R/W, low 8 bits), 0x140 SW (R), 0x180 CYCLE counter (R; write clears), 0x1C0 TX push (W; read returns 0), 0x1C1 STATUS (R; write clears overflow).
REQ-015 SHALL drive mdata combinationally from current mem_cmd/mem_addr (zero-cycle read latency); reads of LED/SW zero-extended to data_width.
REQ-016 SHALL return 0 on MREAD to any selected unmapped address; MWRITE to unmapped address SHALL have no effect.
REQ-017 SHALL never drive mdata when mem_addr[8]=0 or mem_cmd not MREAD.
REQ-018 SHALL perform write side effects exactly once per access: generate an access-start pulse when a selected MWRITE is present and the previous cycle did not hold the same {mem_cmd, mem_addr}; update registers at that edge only.
REQ-019 SHALL hold write effects for a command held N cycles to one (e.g. held 3 cycles at 0x1C0 = one push).
REQ-020 SHALL synchronise sw through two flops; SW reads return the second-stage value (2-cycle latency).
REQ-021 SHALL increment CYCLE by 1 every cycle, wrapping 0xFFFF->0x0000; clear-write SHALL load 0 at that edge, counting resumes next cycle (clear takes precedence over increment).
REQ-022 SHALL implement TX FIFO with read/write pointers and a count of width $clog2(fifo_depth)+1; pointers wrap modulo fifo_depth.
REQ-023 SHALL assert tx_valid iff count>0; tx_data = head entry (undefined contents allowed only when tx_valid=0).
REQ-024 SHALL pop on tx_valid & tx_ready; push on TX access-start.
REQ-025 SHALL, when full with simultaneous pop and push, accept both (count unchanged).
REQ-026 SHALL, on push while full with no pop, drop the word and set sticky overflow.
REQ-027 SHALL read STATUS as {zeros, overflow, full, empty} in bits [2:0]; overflow cleared by STATUS write, set takes precedence if same edge.

Reset
REQ-028 SHALL on reset at an edge set led=0, CYCLE=0, FIFO empty (tx_valid=0), overflow=0, sync flops=0, access-history cleared.
REQ-029 SHALL suppress all pushes, clears and pops in a reset cycle; reset mid-access followed by the same held command SHALL count as a new access-start.
REQ-030 SHALL keep mdata combinational during reset (status reads 0x1 if MREAD 0x1C1 held).

Structure
REQ-031 SHALL place MREAD/MWRITE encodings and register address constants in shared package mmio_pkg used also by cpu.
REQ-032 SHALL implement the FIFO as sub-module tx_fifo (parameters data_width, fifo_depth; push/pop/full/empty/count).

Verification
REQ-033 SHALL check: MWRITE 0x100 din=0x00A5 held 3 cycles -> led=0xA5; MREAD 0x100 -> mdata=0x00A5.
REQ-034 SHALL check: four MWRITEs to 0x1C0 (0x1111..0x4444), tx_ready=0 -> STATUS=0x2; fifth write -> STATUS=0x6, drained order 1111,2222,3333,4444.
REQ-035 SHALL check: FIFO full, tx_ready=1 and push 0x5555 same edge -> count stays 4, no overflow, 0x5555 emerges last.
REQ-036 SHALL check: sw=0x3C applied -> MREAD 0x140 returns 0x003C exactly from the 2nd edge onward.
REQ-037 SHALL check: CYCLE at 0xFFFF wraps to 0; MWRITE 0x180 -> reads 0, then 1 next cycle; mem_addr=0x040 MREAD -> mdata all 'z'.
REQ-038 SHALL check: reset asserted with 2 words queued and overflow set -> next cycle tx_valid=0, STATUS=0x1, led=0.
